// File: rtl/specialist_ram_arbiter.sv
// Shares the single-port sram between the loader, the CPU and the video fetcher.
// One grant at a time: fixed RAM_LAT-cycle strobe window, then a one-cycle ack to the winner.
module specialist_ram_arbiter #(
  parameter int unsigned RAM_LAT = 4,
  parameter int unsigned VID_MAX = 24
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ld_req,
  input  logic [19:0] ld_addr,
  input  logic [7:0]  ld_data,
  output logic        ld_ack,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        vid_req,
  input  logic [19:0] vid_addr,
  output logic [7:0]  vid_rdata,
  output logic        vid_ack,
  output logic [19:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [7:0]  mem_dout
);
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = $clog2(RAM_LAT);
  localparam int unsigned VW = $clog2(VID_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(RAM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  typedef enum logic [1:0] {SRC_LD, SRC_CPU, SRC_VID} src_t;

  state_t        state_q, state_d;
  src_t          src_q, src_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [VW-1:0] vid_wait_q, vid_wait_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_din_q, mem_din_d;
  logic          mem_we_q, mem_we_d;
  logic          mem_rd_q, mem_rd_d;
  logic          ld_ack_q, ld_ack_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic          vid_ack_q, vid_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] vid_rdata_q, vid_rdata_d;

  logic          gnt_valid;
  src_t          gnt_src;
  logic [AW-1:0] gnt_addr;
  logic [DW-1:0] gnt_data;
  logic          gnt_we;
  logic          vid_starved;
  logic          vid_gnt;
  logic          vid_busy;

  assign vid_starved = (vid_wait_q >= VW'(VID_MAX));
  assign vid_gnt     = (state_q == IDLE) && gnt_valid && (gnt_src == SRC_VID);
  assign vid_busy    = (state_q != IDLE) && (src_q == SRC_VID);

  // Priority: loader > starved video > CPU > video
  always_comb begin
    gnt_valid = 1'b1;
    gnt_src   = SRC_LD;
    gnt_addr  = ld_addr;
    gnt_data  = ld_data;
    gnt_we    = 1'b1;
    if (!ld_req) begin
      gnt_data = DW'(0);
      gnt_we   = 1'b0;
      if (vid_req && vid_starved) begin
        gnt_src  = SRC_VID;
        gnt_addr = vid_addr;
      end else if (cpu_req) begin
        gnt_src  = SRC_CPU;
        gnt_addr = cpu_addr;
        gnt_data = cpu_wdata;
        gnt_we   = cpu_we;
      end else if (vid_req) begin
        gnt_src  = SRC_VID;
        gnt_addr = vid_addr;
      end else begin
        gnt_valid = 1'b0;
      end
    end
  end

  // Starvation counter: only counts while video waits behind someone else
  always_comb begin
    vid_wait_d = vid_wait_q;
    if (!vid_req || vid_gnt || vid_busy) begin
      vid_wait_d = VW'(0);
    end else if (!vid_starved) begin
      vid_wait_d = vid_wait_q + VW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_din_d   = mem_din_q;
    mem_we_d    = 1'b0;
    mem_rd_d    = 1'b0;
    ld_ack_d    = 1'b0;
    cpu_ack_d   = 1'b0;
    vid_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d    = ACCESS;
          src_d      = gnt_src;
          cnt_d      = CW'(0);
          mem_addr_d = gnt_addr;
          mem_din_d  = gnt_data;
          mem_we_d   = gnt_we;
          mem_rd_d   = ~gnt_we;
        end
      end
      ACCESS: begin
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          if (mem_rd_q && (src_q == SRC_CPU)) cpu_rdata_d = mem_dout;
          if (mem_rd_q && (src_q == SRC_VID)) vid_rdata_d = mem_dout;
          ld_ack_d  = (src_q == SRC_LD);
          cpu_ack_d = (src_q == SRC_CPU);
          vid_ack_d = (src_q == SRC_VID);
        end else begin
          cnt_d    = cnt_q + CW'(1);
          mem_we_d = mem_we_q;
          mem_rd_d = mem_rd_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      src_q       <= SRC_LD;
      cnt_q       <= CW'(0);
      vid_wait_q  <= VW'(0);
      mem_addr_q  <= AW'(0);
      mem_din_q   <= DW'(0);
      mem_we_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      ld_ack_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vid_ack_q   <= 1'b0;
      cpu_rdata_q <= DW'(0);
      vid_rdata_q <= DW'(0);
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      vid_wait_q  <= vid_wait_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d;
      mem_rd_q    <= mem_rd_d;
      ld_ack_q    <= ld_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      vid_ack_q   <= vid_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  assign ld_ack    = ld_ack_q;
  assign cpu_ack   = cpu_ack_q;
  assign vid_ack   = vid_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign vid_rdata = vid_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_we    = mem_we_q;
  assign mem_rd    = mem_rd_q;

endmodule

// File: tb/tb_specialist_ram_arbiter.sv
// Bench for specialist_ram_arbiter: timeline model of grants/windows/acks checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_specialist_ram_arbiter;
  localparam int RAM_LAT = 4;
  localparam int VID_MAX = 24;
  localparam int ACK_PH  = RAM_LAT + 1;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b0;
  logic        ld_req, ld_ack, cpu_req, cpu_we, cpu_ack, vid_req, vid_ack;
  logic        mem_we, mem_rd;
  logic [19:0] ld_addr, cpu_addr, vid_addr, mem_addr;
  logic [7:0]  ld_data, cpu_wdata, cpu_rdata, vid_rdata, mem_din, mem_dout;

  logic [7:0]  sram [0:1048575];
  logic        pl_en = 1'b0;
  logic [19:0] pl_addr = 20'h0;
  logic [7:0]  pl_data = 8'h0;

  specialist_ram_arbiter #(.RAM_LAT(RAM_LAT), .VID_MAX(VID_MAX)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_ack(vid_ack),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_dout(mem_dout)
  );

  always #5 clk_sys = ~clk_sys;

  // sram stand-in: read data follows the address, writes land on the clock
  assign mem_dout = sram[mem_addr];
  always @(posedge clk_sys) begin
    if (pl_en) sram[pl_addr] <= pl_data;
    else if (mem_we) sram[mem_addr] <= mem_din;
  end

  // Model: phase 0 = free, 1..RAM_LAT = strobe window, RAM_LAT+1 = ack cycle
  int          m_phase, m_owner, m_vwait, gsel;
  logic [19:0] m_addr;
  logic [7:0]  m_data, m_cpu_rd, m_vid_rd;
  logic        m_we;

  function automatic int pick(input logic l, input logic c, input logic v, input int vw);
    if (l) return 0;
    if (v && vw >= VID_MAX) return 2;
    if (c) return 1;
    if (v) return 2;
    return -1;
  endfunction

  function automatic int next_vwait(input logic v, input logic served, input int w);
    if (!v || served) return 0;
    return (w >= VID_MAX) ? VID_MAX : w + 1;
  endfunction

  assign gsel = pick(ld_req, cpu_req, vid_req, m_vwait);

  always @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      m_phase <= 0; m_owner <= 0; m_vwait <= 0; m_we <= 1'b0;
      m_addr <= 20'h0; m_data <= 8'h0; m_cpu_rd <= 8'h0; m_vid_rd <= 8'h0;
    end else begin
      m_vwait <= next_vwait(vid_req,
                            (m_phase != 0 && m_owner == 2) || (m_phase == 0 && gsel == 2), m_vwait);
      if (m_phase == 0) begin
        if (gsel >= 0) begin
          m_owner <= gsel;
          m_phase <= 1;
          m_addr  <= (gsel == 0) ? ld_addr : (gsel == 1) ? cpu_addr : vid_addr;
          m_data  <= (gsel == 0) ? ld_data : cpu_wdata;
          m_we    <= (gsel == 0) ? 1'b1 : (gsel == 1) ? cpu_we : 1'b0;
        end
      end else if (m_phase == ACK_PH) begin
        m_phase <= 0;
      end else begin
        if (m_phase == RAM_LAT && !m_we && m_owner == 1) m_cpu_rd <= sram[m_addr];
        if (m_phase == RAM_LAT && !m_we && m_owner == 2) m_vid_rd <= sram[m_addr];
        m_phase <= m_phase + 1;
      end
    end
  end

  int       checks = 0;
  int       failures = 0;
  int       cyc = 0;
  int       vmax = 0;
  int       n_ack [3];
  int       ack_who [$];
  logic [2:0] ack_now;
  logic     hold_cpu = 1'b0;
  logic     saw_we = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic win;
    win = (m_phase >= 1) && (m_phase <= RAM_LAT);
    chk("mem_rd", int'(mem_rd), int'(win && !m_we));
    chk("mem_we", int'(mem_we), int'(win && m_we));
    if (win) chk("mem_addr", int'(mem_addr), int'(m_addr));
    if (win && m_we) chk("mem_din", int'(mem_din), int'(m_data));
    chk("ld_ack", int'(ld_ack), int'(m_phase == ACK_PH && m_owner == 0));
    chk("cpu_ack", int'(cpu_ack), int'(m_phase == ACK_PH && m_owner == 1));
    chk("vid_ack", int'(vid_ack), int'(m_phase == ACK_PH && m_owner == 2));
    chk("cpu_rdata", int'(cpu_rdata), int'(m_cpu_rd));
    chk("vid_rdata", int'(vid_rdata), int'(m_vid_rd));
    chk("vid_wait", int'(dut.vid_wait_q), m_vwait);
  endtask

  // One cycle: compare at the falling edge, then react to acks like a level-request master
  task automatic step();
    @(negedge clk_sys);
    cyc++;
    compare_cycle();
    ack_now = {vid_ack, cpu_ack, ld_ack};
    for (int k = 0; k < 3; k++) if (ack_now[k]) begin n_ack[k]++; ack_who.push_back(k); end
    if (mem_we) saw_we = 1'b1;
    if (int'(dut.vid_wait_q) > vmax) vmax = int'(dut.vid_wait_q);
    if (ld_ack) ld_req = 1'b0;
    if (cpu_ack && !hold_cpu) cpu_req = 1'b0;
    if (vid_ack) vid_req = 1'b0;
  endtask

  task automatic wait_ack(input int who, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget && at < 0; i++) begin
      step();
      if (ack_now[who]) at = cyc;
    end
    checks++;
    if (at < 0) begin
      failures++;
      $display("FAIL ack_timeout who=%0d actual=none required=ack within %0d cycles", who, budget);
    end
  endtask

  task automatic preload(input logic [19:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_en = 1'b1;
    step();
    pl_en = 1'b0;
  endtask

  initial begin
    int at, start, cnt_before, n_cpu;
    logic [7:0] vid_keep;
    ld_req = 1'b0; cpu_req = 1'b0; vid_req = 1'b0; cpu_we = 1'b0;
    ld_addr = 20'h0; ld_data = 8'h0; cpu_addr = 20'h0; cpu_wdata = 8'h0; vid_addr = 20'h0;
    for (int k = 0; k < 3; k++) n_ack[k] = 0;
    #1 reset = 1'b1;
    preload(20'h1C005, 8'hA5);
    preload(20'h20000, 8'h5A);
    preload(20'h20010, 8'h77);
    step();
    chk("rst_strobes_acks", int'({ld_ack, cpu_ack, vid_ack, mem_we, mem_rd}), 0);
    chk("rst_rdata", int'({cpu_rdata, vid_rdata}), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    reset = 1'b0;
    step();

    // 1: single CPU read; ack lands RAM_LAT+2 cycles counting the granting IDLE cycle
    cpu_addr = 20'h1C005; cpu_we = 1'b0; cpu_req = 1'b1; saw_we = 1'b0; start = cyc;
    wait_ack(1, 20, at);
    chk("t1_grant_to_ack", at - start + 1, 6);
    chk("t1_cpu_rdata", int'(cpu_rdata), 8'hA5);
    chk("t1_no_mem_we", int'(saw_we), 0);
    repeat (2) step();

    // 2: all three at once -> loader, CPU, video
    ack_who.delete();
    ld_addr = 20'h05000; ld_data = 8'hC3; ld_req = 1'b1;
    cpu_req = 1'b1; vid_addr = 20'h20000; vid_req = 1'b1;
    wait_ack(2, 40, at);
    chk("t2_ack_count", ack_who.size(), 3);
    if (ack_who.size() == 3) begin
      chk("t2_first_ld", ack_who[0], 0);
      chk("t2_second_cpu", ack_who[1], 1);
      chk("t2_third_vid", ack_who[2], 2);
    end
    chk("t2_vid_rdata", int'(vid_rdata), 8'h5A);
    chk("t2_ld_written", int'(sram[20'h05000]), 8'hC3);
    repeat (2) step();

    // 3: CPU hogs the bus; video wins after 4 CPU rounds (6 waited cycles per round)
    ack_who.delete(); vmax = 0; hold_cpu = 1'b1;
    cpu_req = 1'b1; vid_addr = 20'h20010; vid_req = 1'b1;
    wait_ack(2, 80, at);
    hold_cpu = 1'b0; cpu_req = 1'b0;
    n_cpu = 0;
    foreach (ack_who[i]) if (ack_who[i] == 1) n_cpu++;
    chk("t3_cpu_acks_before_vid", n_cpu, 4);
    chk("t3_vid_wait_peak", vmax, 24);
    chk("t3_vid_rdata", int'(vid_rdata), 8'h77);
    step();
    chk("t3_vid_wait_cleared", int'(dut.vid_wait_q), 0);
    repeat (8) step();

    // 4: CPU write then read-back; read data of other ports untouched
    vid_keep = vid_rdata;
    cpu_addr = 20'h0C000; cpu_wdata = 8'h3C; cpu_we = 1'b1; cpu_req = 1'b1;
    wait_ack(1, 20, at);
    chk("t4_rdata_kept_on_write", int'(cpu_rdata), 8'hA5);
    repeat (2) step();
    cpu_we = 1'b0; cpu_req = 1'b1;
    wait_ack(1, 20, at);
    chk("t4_readback", int'(cpu_rdata), 8'h3C);
    chk("t4_vid_rdata_same", int'(vid_rdata), int'(vid_keep));
    chk("t4_vid_rdata_lit", int'(vid_rdata), 8'h77);
    repeat (2) step();

    // 5: reset in the 2nd strobe cycle of a CPU write
    cnt_before = n_ack[1];
    cpu_addr = 20'h0C001; cpu_wdata = 8'h11; cpu_we = 1'b1; cpu_req = 1'b1;
    repeat (2) step();
    chk("t5_we_before_reset", int'(mem_we), 1);
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    chk("t5_we_drops_at_reset", int'(mem_we), 0);
    repeat (2) step();
    reset = 1'b0;
    repeat (8) step();
    chk("t5_no_cpu_ack", n_ack[1] - cnt_before, 0);
    cpu_addr = 20'h1C005; cpu_req = 1'b1; start = cyc;
    wait_ack(1, 20, at);
    chk("t5_idle_after_release", at - start + 1, 6);
    chk("t5_read_after_reset", int'(cpu_rdata), 8'hA5);
    repeat (2) step();

    // 6: video request withdrawn before it is granted
    cnt_before = n_ack[2]; vmax = 0;
    cpu_addr = 20'h1C005; cpu_req = 1'b1;
    step();
    vid_addr = 20'h20000; vid_req = 1'b1;
    repeat (2) step();
    chk("t6_vid_wait_counting", int'(dut.vid_wait_q), 2);
    vid_req = 1'b0;
    repeat (10) step();
    chk("t6_no_vid_ack", n_ack[2] - cnt_before, 0);
    chk("t6_vid_wait_zero", int'(dut.vid_wait_q), 0);
    chk("t6_vid_wait_peak", vmax, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
